// File: rtl/mul32_arbiter_pkg.sv
// Shared definitions for the two-requester mul32 arbiter.
// Covers the FSM state encoding, the mode encoding and the operand width.
package mul32_arbiter_pkg;

   localparam int unsigned OPW = 32;

   localparam logic MODE_SIGNED   = 1'b1;
   localparam logic MODE_UNSIGNED = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mul32_arbiter_if.sv
// One requester's operand and response handshake.
// The requester side uses the master modport; the arbiter side uses the slave modport.
interface mul32_arbiter_if;
   import mul32_arbiter_pkg::*;

   logic           valid;
   logic           ready;
   logic [OPW-1:0] a;
   logic [OPW-1:0] b;
   logic           mode;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [OPW-1:0] lo;
   logic [OPW-1:0] hi;

   modport master (
      output valid, a, b, mode, rsp_ready,
      input  ready, rsp_valid, lo, hi
   );

   modport slave (
      input  valid, a, b, mode, rsp_ready,
      output ready, rsp_valid, lo, hi
   );

endinterface

// File: rtl/mul32.sv
// Combinational 32x32->64 multiplier; mode selects signed or unsigned operands.
// T is the propagation-delay figure carried for the timing flow; it does not alter the function.
module mul32
   import mul32_arbiter_pkg::*;
#(
   parameter real T = 0.150
) (
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   input  logic           mode,
   output logic [OPW-1:0] hi,
   output logic [OPW-1:0] lo
);

   logic              sx_s;
   logic [2*OPW-1:0]  a_ext_s;
   logic [2*OPW-1:0]  b_ext_s;
   logic [2*OPW-1:0]  prod_s;

   if (T < 0.0) begin : g_t_check
      $error("mul32: T must not be negative");
   end

   // Extending to 64 bits and keeping the low 64 product bits yields the two's-complement result
   assign sx_s    = (mode == MODE_SIGNED);
   assign a_ext_s = {{OPW{sx_s & a[OPW-1]}}, a};
   assign b_ext_s = {{OPW{sx_s & b[OPW-1]}}, b};
   assign prod_s  = a_ext_s * b_ext_s;
   assign hi      = prod_s[2*OPW-1:OPW];
   assign lo      = prod_s[OPW-1:0];

endmodule

// File: rtl/mul32_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: the pointer breaks ties and moves past the winner on advance.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr_q;
   logic ptr_d;

   // One-hot grant; ptr_q = 0 favours requester 0 when both request
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // After a grant the pointer turns to the requester that lost
   always_comb begin
      if (advance) begin
         ptr_d = grant[0];
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mul32_arbiter.sv
// Shares one combinational mul32 between two requesters: accept, hold operands
// for WAIT_CYCLES clocks, capture the product and return it to the owner.
module mul32_arbiter
   import mul32_arbiter_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter real         MUL_T       = 0.150
) (
   input  logic           clk,
   input  logic           rst_n,
   mul32_arbiter_if.slave r0,
   mul32_arbiter_if.slave r1,
   output logic           busy
);

   localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 32'd1);

   if (WAIT_CYCLES < 32'd1) begin : g_wait_check
      $error("mul32_arbiter: WAIT_CYCLES must be at least 1");
   end

   state_e                    state_q;
   logic [CW-1:0]             cnt_q;
   logic [OPW-1:0]            a_q;
   logic [OPW-1:0]            b_q;
   logic                      mode_q;
   logic                      owner_q;
   logic                      busy_q;
   logic [1:0]                rsp_valid_q;
   logic [1:0][2*OPW-1:0]     res_q;

   logic [1:0]                req_s;
   logic [1:0]                grant_s;
   logic [1:0]                rsp_ready_s;
   logic                      idle_s;
   logic                      accept_s;
   logic [OPW-1:0]            mul_hi_s;
   logic [OPW-1:0]            mul_lo_s;

   assign req_s       = {r1.valid, r0.valid};
   assign rsp_ready_s = {r1.rsp_ready, r0.rsp_ready};
   assign idle_s      = (state_q == ST_IDLE);
   assign accept_s    = idle_s && ((req_s & grant_s) != 2'b00);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_s),
      .advance (accept_s),
      .grant   (grant_s)
   );

   mul32 #(.T(MUL_T)) u_mul (
      .a    (a_q),
      .b    (b_q),
      .mode (mode_q),
      .hi   (mul_hi_s),
      .lo   (mul_lo_s)
   );

   // Operation sequencer: operand capture, settle countdown, product capture, response handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= CW'(0);
         a_q         <= {OPW{1'b0}};
         b_q         <= {OPW{1'b0}};
         mode_q      <= 1'b0;
         owner_q     <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 2'b00;
         res_q       <= {(4*OPW){1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  a_q     <= grant_s[1] ? r1.a : r0.a;
                  b_q     <= grant_s[1] ? r1.b : r0.b;
                  mode_q  <= grant_s[1] ? r1.mode : r0.mode;
                  owner_q <= grant_s[1];
                  cnt_q   <= CNT_LOAD;
                  busy_q  <= 1'b1;
                  state_q <= ST_BUSY;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               // Operands have been stable for WAIT_CYCLES clocks once the count hits zero
               if (cnt_q == CW'(0)) begin
                  res_q[owner_q]       <= {mul_hi_s, mul_lo_s};
                  rsp_valid_q[owner_q] <= 1'b1;
                  state_q              <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            ST_DONE: begin
               if (rsp_ready_s[owner_q]) begin
                  rsp_valid_q <= 2'b00;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  state_q <= ST_DONE;
               end
            end
            default: begin
               rsp_valid_q <= 2'b00;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign r0.ready     = idle_s && grant_s[0];
   assign r1.ready     = idle_s && grant_s[1];
   assign r0.rsp_valid = rsp_valid_q[0];
   assign r1.rsp_valid = rsp_valid_q[1];
   assign r0.lo        = res_q[0][OPW-1:0];
   assign r0.hi        = res_q[0][2*OPW-1:OPW];
   assign r1.lo        = res_q[1][OPW-1:0];
   assign r1.hi        = res_q[1][2*OPW-1:OPW];
   assign busy         = busy_q;

endmodule

// File: tb/tb_mul32_arbiter.sv
// Scoreboard bench for mul32_arbiter: accepts push reference products, a monitor
// pops and compares on every response handshake.
module tb_mul32_arbiter;
   import mul32_arbiter_pkg::*;

   localparam int unsigned W = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   logic [1:0] hold = 2'b00;
   logic       rand_stall = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [63:0] exp_q0 [$];
   logic [63:0] exp_q1 [$];
   int          order_q [$];
   logic [63:0] last_prod [2];
   logic [63:0] mon_e;

   mul32_arbiter_if r0_if ();
   mul32_arbiter_if r1_if ();

   mul32_arbiter #(.WAIT_CYCLES(W), .MUL_T(0.150)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .r0    (r0_if),
      .r1    (r1_if),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic m);
      longint sa;
      longint sb;
      if (m == MODE_SIGNED) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response-side ready: held low on request, otherwise random stalls when enabled
   always @(posedge clk) begin
      #2;
      r0_if.rsp_ready = hold[0] ? 1'b0 : (rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1);
      r1_if.rsp_ready = hold[1] ? 1'b0 : (rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1);
   end

   // Reset discards any in-flight expectation
   always @(negedge rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
   end

   // Monitor: push on accept, pop and compare on response handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (r0_if.valid && r0_if.ready) exp_q0.push_back(ref_mul(r0_if.a, r0_if.b, r0_if.mode));
         if (r1_if.valid && r1_if.ready) exp_q1.push_back(ref_mul(r1_if.a, r1_if.b, r1_if.mode));
         if (r0_if.ready || r1_if.ready)
            chk("ready_excl", {62'd0, busy, r0_if.ready & r1_if.ready}, 64'd0);
         if (r0_if.rsp_valid || r1_if.rsp_valid)
            chk("rsp_excl", {63'd0, r0_if.rsp_valid & r1_if.rsp_valid}, 64'd0);
         if (r0_if.rsp_valid && r0_if.rsp_ready) begin
            if (exp_q0.size() == 0) begin
               checks++; errors++;
               $display("FAIL extra_rsp0: got response %h expected none", {r0_if.hi, r0_if.lo});
            end else begin
               mon_e = exp_q0.pop_front();
               chk("prod_r0", {r0_if.hi, r0_if.lo}, mon_e);
            end
            last_prod[0] = {r0_if.hi, r0_if.lo};
            order_q.push_back(0);
         end
         if (r1_if.rsp_valid && r1_if.rsp_ready) begin
            if (exp_q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL extra_rsp1: got response %h expected none", {r1_if.hi, r1_if.lo});
            end else begin
               mon_e = exp_q1.pop_front();
               chk("prod_r1", {r1_if.hi, r1_if.lo}, mon_e);
            end
            last_prod[1] = {r1_if.hi, r1_if.lo};
            order_q.push_back(1);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b, input logic m);
      int  n;
      logic rdy;
      n = 0;
      if (k == 0) begin
         r0_if.a = a; r0_if.b = b; r0_if.mode = m; r0_if.valid = 1'b1;
      end else begin
         r1_if.a = a; r1_if.b = b; r1_if.mode = m; r1_if.valid = 1'b1;
      end
      do begin
         @(negedge clk);
         n++;
         rdy = (k == 0) ? r0_if.ready : r1_if.ready;
      end while (!rdy && n < 400);
      if (!rdy) begin
         checks++; errors++;
         $display("FAIL accept_timeout_r%0d: ready 0 after %0d cycles, required 1", k, n);
      end
      @(posedge clk);
      #1;
      if (k == 0) r0_if.valid = 1'b0;
      else        r1_if.valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while ((busy || exp_q0.size() != 0 || exp_q1.size() != 0) && n < 3000);
      chk(name, {62'd0, busy, (exp_q0.size() != 0 || exp_q1.size() != 0)}, 64'd0);
   endtask

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic rand_stream(input int k, input int nops);
      for (int i = 0; i < nops; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         issue(k, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      logic [63:0] snap;
      logic [63:0] ov;
      int          n;

      r0_if.valid = 1'b0; r0_if.a = 32'd0; r0_if.b = 32'd0; r0_if.mode = 1'b0;
      r1_if.valid = 1'b0; r1_if.a = 32'd0; r1_if.b = 32'd0; r1_if.mode = 1'b0;
      r0_if.rsp_ready = 1'b0;
      r1_if.rsp_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_flags", {59'd0, r0_if.ready, r1_if.ready, r0_if.rsp_valid, r1_if.rsp_valid, busy}, 64'd0);
      chk("reset_r0_res", {r0_if.hi, r0_if.lo}, 64'd0);
      chk("reset_r1_res", {r1_if.hi, r1_if.lo}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Contention from reset: r0 first, r1 next, a second r0 request waits behind r1
      fork
         begin
            issue(0, 32'd3, 32'd5, 1'b0);
            issue(0, 32'd9, 32'd9, 1'b0);
         end
         issue(1, 32'd7, 32'd11, 1'b0);
      join
      wait_idle("idle_contention");
      ov = 64'd0;
      foreach (order_q[i]) ov = {ov[59:0], 4'(order_q[i] + 1)};
      chk("contention_order", ov, 64'h121);
      chk("contention_r1", last_prod[1], 64'd77);
      chk("contention_r0", last_prod[0], 64'd81);
      order_q.delete();

      // Single op with latency and idle-peer checks
      fork
         issue(0, 32'd292, 32'd6785, 1'b0);
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!(r0_if.valid && r0_if.ready) && n < 50);
            for (int i = 1; i <= int'(W) + 1; i++) begin
               @(negedge clk);
               chk("latency_rsp_valid", {63'd0, r0_if.rsp_valid}, {63'd0, i == int'(W) + 1});
               chk("r1_quiet", {63'd0, r1_if.rsp_valid}, 64'd0);
            end
         end
      join
      wait_idle("idle_single");
      chk("single_prod", last_prod[0], 64'd1981220);

      // Mode selection on an all-ones operand
      issue(0, 32'hFFFF_FFFF, 32'd2, 1'b0);
      wait_idle("idle_mode_u");
      chk("mode_unsigned", last_prod[0], 64'h0000_0001_FFFF_FFFE);
      issue(0, 32'hFFFF_FFFF, 32'd2, 1'b1);
      wait_idle("idle_mode_s");
      chk("mode_signed", last_prod[0], 64'hFFFF_FFFF_FFFF_FFFE);

      // Backpressure on r1 while r0 is waiting
      hold[1] = 1'b1;
      issue(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      n = 0;
      while (!r1_if.rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      snap = {r1_if.hi, r1_if.lo};
      chk("bp_value", snap, ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b1));
      fork
         issue(0, 32'd5, 32'd6, 1'b1);
         begin
            repeat (10) begin
               @(negedge clk);
               chk("bp_hold", {r1_if.hi, r1_if.lo}, snap);
               chk("bp_flags", {61'd0, r1_if.rsp_valid, busy, r0_if.ready}, 64'd6);
            end
            @(posedge clk);
            #1;
            hold[1] = 1'b0;
         end
      join
      wait_idle("idle_bp");
      chk("bp_r0_after", last_prod[0], 64'd30);

      // Reset one cycle after accept discards the operation
      issue(0, 32'd1234, 32'd5678, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_flags", {59'd0, r0_if.ready, r1_if.ready, r0_if.rsp_valid, r1_if.rsp_valid, busy}, 64'd0);
      chk("rst_r0_res", {r0_if.hi, r0_if.lo}, 64'd0);
      chk("rst_r1_res", {r1_if.hi, r1_if.lo}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (W + 4) begin
         @(negedge clk);
         chk("rst_no_rsp", {62'd0, r0_if.rsp_valid, r1_if.rsp_valid}, 64'd0);
      end
      @(posedge clk);
      #1;
      issue(0, 32'd0, 32'hDEAD_BEEF, 1'b1);
      wait_idle("idle_after_rst");
      chk("after_rst_zero", last_prod[0], 64'd0);

      // Random traffic on both requesters with response stalls
      rand_stall = 1'b1;
      fork
         rand_stream(0, 500);
         rand_stream(1, 500);
      join
      rand_stall = 1'b0;
      wait_idle("idle_random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
